// File: rtl/uart_tx_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// uart_tx_ctrl_pkg
//
// Shared definitions for the UART transmit controller and its testbench:
//   - state_e   : controller FSM state encoding
//   - *_LVL     : UART line levels for idle, start and stop bits
//   - LAST_BIT  : index of the final data bit in a frame
// -----------------------------------------------------------------------------
package uart_tx_ctrl_pkg;

   // Controller FSM states. The encoding is explicit so that waveforms
   // and the bench can rely on fixed values.
   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } state_e;

   // UART line levels.
   localparam logic IDLE_LVL  = 1'b1;
   localparam logic START_LVL = 1'b0;
   localparam logic STOP_LVL  = 1'b1;

   // Bits per character. The final data bit has index LAST_BIT.
   localparam int unsigned DATA_BITS = 8;
   localparam logic [2:0]  LAST_BIT  = 3'(DATA_BITS - 1);

endpackage : uart_tx_ctrl_pkg

// File: rtl/uart_tx_ctrl_parity_calc.sv
// -----------------------------------------------------------------------------
// parity_calc
//
// Computes the parity bit for one 8-bit character.
//   data_i    : character whose parity is computed
//   par_typ_i : 0 = even parity, 1 = odd parity
//   par_o     : parity bit to transmit
//
// Even parity sends the XOR of the data bits, which makes the total number
// of ones even. Odd parity sends the inverse of that XOR.
// -----------------------------------------------------------------------------
module parity_calc (
   input  logic [7:0] data_i,
   input  logic       par_typ_i,
   output logic       par_o
);

   assign par_o = (^data_i) ^ par_typ_i;

endmodule : parity_calc

// File: rtl/uart_tx_ctrl.sv
// -----------------------------------------------------------------------------
// uart_tx_ctrl
//
// Frame controller for a UART transmitter. It works with an external
// serializer that shifts the data bits out LSB first. The controller
// builds the frame as: start bit, data bits supplied by the serializer,
// an optional parity bit, then STOP_BITS stop bits.
//
// Parameters
//   STOP_BITS  : stop bits per frame (1 or 2)
//
// Ports
//   CLK        : clock; all state changes happen on its rising edge
//   RST        : asynchronous, active-low reset
//   P_DATA     : parallel byte; sampled only when a request is accepted
//   DATA_VALID : byte request; accepted in IDLE or in the last STOP cycle
//   PAR_EN     : parity enable; sampled when a request is accepted
//   PAR_TYP    : parity type (0 even, 1 odd); sampled when a request is accepted
//   SER_DATA   : current serial data bit from the serializer
//   SER_DONE   : serializer flag; high in the cycle that carries bit 7
//   SER_EN     : serializer shift enable; decoded combinationally from state
//   TX_OUT     : registered UART line
//   BUSY       : high whenever a frame is in progress
//   SEQ_ERR    : sticky flag; set when SER_DONE and the bit count disagree
// -----------------------------------------------------------------------------
module uart_tx_ctrl
   import uart_tx_ctrl_pkg::*;
#(
   parameter int STOP_BITS = 1
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic [7:0] P_DATA,
   input  logic       DATA_VALID,
   input  logic       PAR_EN,
   input  logic       PAR_TYP,
   input  logic       SER_DATA,
   input  logic       SER_DONE,
   output logic       SER_EN,
   output logic       TX_OUT,
   output logic       BUSY,
   output logic       SEQ_ERR
);

   // Value the stop counter holds in the final stop cycle. With one stop
   // bit the first STOP cycle is also the last one.
   localparam logic STOP_LAST = (STOP_BITS == 2);

   // ---------------------------------------------------------------------
   // State and datapath registers
   // ---------------------------------------------------------------------
   state_e     state_q,   state_d;
   logic [2:0] bit_cnt_q, bit_cnt_d;   // DATA cycles seen so far (0..7)
   logic       stop_cnt_q, stop_cnt_d; // STOP cycles seen so far
   logic [7:0] data_q,    data_d;      // byte latched at acceptance
   logic       par_en_q,  par_en_d;
   logic       par_typ_q, par_typ_d;
   logic       tx_q,      tx_d;
   logic       seq_err_q, seq_err_d;

   // Combinational decodes
   logic       par_bit;   // parity of the latched byte
   logic       line_val;  // line level for the current state
   logic       ser_en_c;
   logic       accept;    // a new byte is latched on this edge

   parity_calc u_parity (
      .data_i    (data_q),
      .par_typ_i (par_typ_q),
      .par_o     (par_bit)
   );

   // ---------------------------------------------------------------------
   // Next-state and output decode
   // ---------------------------------------------------------------------
   // NOTE: every signal written here gets a default before the case
   // statement, so no path can leave it unassigned and infer a latch.
   always_comb begin
      state_d    = state_q;
      bit_cnt_d  = '0;          // the counter is cleared outside DATA
      stop_cnt_d = 1'b0;
      data_d     = data_q;
      par_en_d   = par_en_q;
      par_typ_d  = par_typ_q;
      seq_err_d  = seq_err_q;
      line_val   = IDLE_LVL;
      ser_en_c   = 1'b0;
      accept     = 1'b0;

      unique case (state_q)
         IDLE: begin
            line_val = IDLE_LVL;
            accept   = DATA_VALID;
         end

         START: begin
            // The serializer shifts on the START->DATA edge, so SER_DATA
            // carries bit 0 in the first DATA cycle.
            line_val = START_LVL;
            ser_en_c = 1'b1;
            state_d  = DATA;
         end

         DATA: begin
            line_val = SER_DATA;
            ser_en_c = !SER_DONE;
            if (SER_DONE || (bit_cnt_q == LAST_BIT)) begin
               state_d = par_en_q ? PARITY : STOP;
               // A clean exit needs SER_DONE exactly in the 8th cycle.
               // An early SER_DONE, or a missing SER_DONE in the 8th
               // cycle, is a sequencing error.
               if (!(SER_DONE && (bit_cnt_q == LAST_BIT))) begin
                  seq_err_d = 1'b1;
               end
            end else begin
               bit_cnt_d = bit_cnt_q + 3'd1;
            end
         end

         PARITY: begin
            line_val = par_bit;
            state_d  = STOP;
         end

         STOP: begin
            line_val = STOP_LVL;
            if (stop_cnt_q == STOP_LAST) begin
               // A new request may start the next frame here, with no
               // idle cycle between the frames.
               if (DATA_VALID) begin
                  accept = 1'b1;
               end else begin
                  state_d = IDLE;
               end
            end else begin
               stop_cnt_d = stop_cnt_q + 1'b1;
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase

      if (accept) begin
         state_d   = START;
         data_d    = P_DATA;
         par_en_d  = PAR_EN;
         par_typ_d = PAR_TYP;
      end

      // The line is registered: every bit appears one cycle after the
      // state that produces it, the same delay for every bit.
      tx_d = line_val;
   end

   // ---------------------------------------------------------------------
   // Registers
   // ---------------------------------------------------------------------
   // NOTE: sequential state uses non-blocking assignments only. All flops
   // then update together at the edge and read only pre-edge values.
   // NOTE: the latched byte is reset with the control state. It is a single
   // register, not a memory, so resetting it is cheap and gives the parity
   // input a known value after reset.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state_q    <= IDLE;
         bit_cnt_q  <= '0;
         stop_cnt_q <= 1'b0;
         data_q     <= '0;
         par_en_q   <= 1'b0;
         par_typ_q  <= 1'b0;
         tx_q       <= IDLE_LVL;
         seq_err_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         bit_cnt_q  <= bit_cnt_d;
         stop_cnt_q <= stop_cnt_d;
         data_q     <= data_d;
         par_en_q   <= par_en_d;
         par_typ_q  <= par_typ_d;
         tx_q       <= tx_d;
         seq_err_q  <= seq_err_d;
      end
   end

   // ---------------------------------------------------------------------
   // Outputs
   // ---------------------------------------------------------------------
   assign SER_EN  = ser_en_c;
   assign TX_OUT  = tx_q;
   assign BUSY    = (state_q != IDLE);
   assign SEQ_ERR = seq_err_q;

endmodule : uart_tx_ctrl

// File: doc/uart_tx_ctrl.md
UART_TX_CTRL -- requirements
Module: uart_tx_ctrl

Interface
REQ-001 SHALL have parameter STOP_BITS, default 1, number of stop bits per frame (legal values 1 or 2).
REQ-002 SHALL have port CLK  input  1  single clock; all state changes on its rising edge.
REQ-003 SHALL have port RST  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port P_DATA  input  8  parallel byte, sampled only when accepted.
REQ-005 SHALL have port DATA_VALID  input  1  byte request; accepted only when BUSY=0.
REQ-006 SHALL have port PAR_EN  input  1  parity bit enable, sampled on acceptance.
REQ-007 SHALL have port PAR_TYP  input  1  parity type, 0=even, 1=odd, sampled on acceptance.
REQ-008 SHALL have port SER_DATA  input  1  serial bit from the serializer.
REQ-009 SHALL have port SER_DONE  input  1  serializer flag, high during the cycle carrying bit 7.
REQ-010 SHALL have port SER_EN  output  1  serializer enable, combinational from state.
REQ-011 SHALL have port TX_OUT  output  1  UART line, registered.
REQ-012 SHALL have port BUSY  output  1  frame in progress.
REQ-013 SHALL have port SEQ_ERR  output  1  sticky serializer-sequence error flag.

Function
REQ-014 SHALL implement FSM states IDLE, START, DATA, PARITY, STOP.
REQ-015 IDLE -> START SHALL occur when DATA_VALID=1, latching P_DATA, PAR_EN and PAR_TYP in that same edge.
REQ-016 START SHALL last exactly 1 cycle, then go to DATA.
REQ-017 DATA SHALL exit on the cycle in which SER_DONE=1, going to PARITY if latched PAR_EN=1, else to STOP.
REQ-018 DATA SHALL also exit after 8 cycles without SER_DONE, taking the same next state and setting SEQ_ERR.
REQ-019 SEQ_ERR SHALL also be set if SER_DONE=1 before the 8th DATA cycle; it clears only on reset.
REQ-020 A 3-bit internal bit counter SHALL count DATA cycles (0..7), be cleared in every other state, and never wrap inside DATA.
REQ-021 PARITY SHALL last 1 cycle, then go to STOP.
REQ-022 STOP SHALL last STOP_BITS cycles.
REQ-023 At the end of STOP, the FSM SHALL go to START (accepting and latching a new byte on that edge) if DATA_VALID=1, else to IDLE.
REQ-024 SER_EN SHALL be 1 in START, and in DATA while SER_DONE=0; it SHALL be 0 otherwise. This aligns the serializer's first shift with the START->DATA edge.
REQ-025 The line value per state SHALL be: IDLE=1, START=0, DATA=SER_DATA, PARITY=parity bit, STOP=1.
REQ-026 TX_OUT SHALL register the REQ-025 line value, so the line lags the state by exactly 1 cycle, uniformly for every bit.
REQ-027 The parity bit SHALL be the XOR of the latched byte when PAR_TYP=0, and its inverse when PAR_TYP=1.
REQ-028 BUSY SHALL be 1 in every state except IDLE.
REQ-029 DATA_VALID SHALL be ignored while BUSY=1, except at the final STOP cycle per REQ-023.
REQ-030 P_DATA, PAR_EN and PAR_TYP changes after acceptance SHALL NOT affect the frame in flight.
REQ-031 Frame length SHALL be 1+8+PAR_EN+STOP_BITS cycles.

Reset
REQ-032 Asserting RST at any time, including mid-frame, SHALL immediately force state=IDLE, TX_OUT=1, BUSY=0, SER_EN=0, SEQ_ERR=0, latched byte=0, bit counter=0.
REQ-033 After RST deasserts, the first DATA_VALID=1 seen in IDLE SHALL start a frame on the next edge.

Structure
REQ-034 A shared package SHALL hold the state encoding constants (IDLE, START, DATA, PARITY, STOP) and the line-level constants (IDLE_LVL=1, START_LVL=0, STOP_LVL=1), for use by the controller and its bench.
REQ-035 The block SHALL be one module. A sub-module parity_calc (8-bit in, type in, 1-bit out) is permitted; no other sub-modules.

Verification
REQ-036 Reset, then DATA_VALID=1, P_DATA=0xA5, PAR_EN=1, PAR_TYP=0, with a conforming serializer model -> TX_OUT sequence 0,1,0,1,0,0,1,0,1,0,1, then idle 1; BUSY high for 11 cycles.
REQ-037 P_DATA=0x01, PAR_EN=1, PAR_TYP=1 -> parity bit 0; PAR_EN=0 -> 10-cycle frame with no parity cycle.
REQ-038 STOP_BITS=2, DATA_VALID held high with bytes 0x55 then 0x0F -> second start bit follows the 2nd stop bit with no idle cycle; both bytes transmitted intact.
REQ-039 RST asserted in the 4th DATA cycle -> TX_OUT=1, BUSY=0 asynchronously; next request 0x3C sends a clean frame.
REQ-040 Serializer model raises SER_DONE in DATA cycle 5 -> SEQ_ERR=1, state goes to PARITY/STOP; SER_DONE never raised -> exit after 8 cycles, SEQ_ERR=1.
REQ-041 DATA_VALID pulsed with 0x77 while BUSY=1 mid-DATA -> ignored, and the in-flight byte is unchanged.
